sqm_arbiter: RTL

//  Shares one combinational sqm datapath (a[7:0], b[3:0] -> c[7:0], y[7:0]) among NREQ requesters.

---
 rtl/sqm_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/sqm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sqm_arbiter
//  Description : Round-robin arbiter that shares one combinational sqm
//                datapath among NREQ requesters. It registers the winning
//                operands, waits SETTLE_CYC cycles for c/y to settle, then
//                returns the result with the owner id on one shared
//                valid/ready response channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module sqm_arbiter #(
    parameter  int NREQ       = 4,
    parameter  int SETTLE_CYC = 1,
    localparam int IDW        = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        sqm_a,
    output logic [3:0]        sqm_b,
    input  logic [7:0]        sqm_c,
    input  logic [7:0]        sqm_y,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [7:0]        rsp_c,
    output logic [7:0]        rsp_y,
    input  logic              rsp_ready
);

    localparam logic [1:0]     c_st_idle  = 2'd0;
    localparam logic [1:0]     c_st_issue = 2'd1;
    localparam logic [1:0]     c_st_resp  = 2'd2;
    localparam logic [3:0]     c_last_cnt = 4'(SETTLE_CYC - 1);
    localparam logic [IDW-1:0] c_last_id  = IDW'(NREQ - 1);

    logic [1:0]     r_state;
    logic [IDW-1:0] r_rr_ptr;
    logic [3:0]     r_cnt;

    logic [7:0]     w_a_arr [NREQ];
    logic [3:0]     w_b_arr [NREQ];
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0] w_grant_id;
    logic [IDW-1:0] w_idx;
    logic           w_accept;
    int             w_probe;

    // Split the flat operand buses into per-requester lanes.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
            assign w_a_arr[gi] = req_a[8*gi +: 8];
            assign w_b_arr[gi] = req_b[4*gi +: 4];
        end
    endgenerate

    // Round-robin search starting at r_rr_ptr; scanning from the far end
    // downward lets the requester closest to the pointer win.
    always_comb begin
        w_grant    = '0;
        w_grant_id = '0;
        w_idx      = '0;
        w_probe    = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_probe = int'(r_rr_ptr) + k;
            if (w_probe >= NREQ) begin
                w_probe = w_probe - NREQ;
            end
            w_idx = IDW'(w_probe);
            if (req_valid[w_idx]) begin
                w_grant        = '0;
                w_grant[w_idx] = 1'b1;
                w_grant_id     = w_idx;
            end
        end
    end

    // Grants are offered only in IDLE and never while reset is asserted.
    assign req_ready = (rst_n && (r_state == c_st_idle)) ? w_grant : '0;
    assign w_accept  = |(req_valid & req_ready);

    // Issue / settle / respond sequencer with operand and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_rr_ptr  <= '0;
            r_cnt     <= '0;
            sqm_a     <= '0;
            sqm_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_c     <= '0;
            rsp_y     <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        sqm_a    <= w_a_arr[w_grant_id];
                        sqm_b    <= w_b_arr[w_grant_id];
                        rsp_id   <= w_grant_id;
                        r_rr_ptr <= (w_grant_id == c_last_id) ? '0 : w_grant_id + 1'b1;
                        r_cnt    <= '0;
                        r_state  <= c_st_issue;
                    end
                end
                c_st_issue: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == c_last_cnt) begin
                        rsp_c     <= sqm_c;
                        rsp_y     <= sqm_y;
                        rsp_valid <= 1'b1;
                        r_state   <= c_st_resp;
                    end
                end
                c_st_resp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
